// File: rtl/l1icache_nway.sv
// l1icache_nway: N-way set-associative instruction cache with an uncached MMIO window,
// round-robin replacement and a one-set-per-cycle invalidate sweep.
//
// state    | meaning
// IDLE     | lookup; a hit returns its word in the same cycle
// REFILL   | line read outstanding at the MMU
// FILL     | mark the returned line valid, advance the set's victim pointer
// MMIO     | uncached word read outstanding at the MMU
// MMIO_RET | present the latched MMIO word for one cycle
// INVAL    | clear valid bits of every way, one set per cycle
module l1icache_nway #(
  parameter int          WAYS      = 2,
  parameter int          SETS      = 512,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter logic [31:0] MMIO_MASK = 32'hFFFF_0000
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         l1_read,
  input  logic [31:0]  l1_addr,
  input  logic         l1_inval,
  output logic [31:0]  l1_data_o,
  output logic         hit,
  output logic         stall,
  output logic         l1_mmu_req_read,
  output logic [31:0]  l1_mmu_req_addr,
  input  logic         mmu_l1_done,
  input  logic [255:0] mmu_l1_read_data
);
  localparam int IW   = $clog2(SETS);
  localparam int TAGW = 27 - IW;
  localparam int VW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REFILL, S_FILL, S_MMIO, S_MMIO_RET, S_INVAL
  } state_t;

  state_t                      state;
  logic [SETS-1:0][WAYS-1:0]   valid_q;
  logic [SETS-1:0][VW-1:0]     victim_q;
  logic [TAGW-1:0]             tag_q  [SETS][WAYS];
  logic [255:0]                line_q [SETS][WAYS];
  logic                        inval_pend;
  logic [31:0]                 mmio_word;
  logic [IW-1:0]               inv_cnt;
  logic [IW-1:0]               inv_idx;

  logic [2:0]      offs;
  logic [IW-1:0]   idx;
  logic [TAGW-1:0] tag;
  logic            is_mmio;
  logic            lookup;
  logic [WAYS-1:0] match;
  logic [255:0]    hit_line;
  logic [31:0]     hit_word;

  logic [IW-1:0]   fill_idx;
  logic [TAGW-1:0] fill_tag;
  logic [VW-1:0]   victim;
  logic [VW-1:0]   victim_next;

  assign offs    = l1_addr[4:2];
  assign idx     = l1_addr[IW+4:5];
  assign tag     = l1_addr[31:IW+5];
  assign is_mmio = ((l1_addr & MMIO_MASK) == MMIO_BASE);
  assign lookup  = l1_read && !is_mmio && (state == S_IDLE);

  // The outstanding line address doubles as the fill target, so the fill
  // does not depend on the requester holding l1_addr.
  assign fill_idx = l1_mmu_req_addr[IW+4:5];
  assign fill_tag = l1_mmu_req_addr[31:IW+5];
  assign inv_idx  = ~inv_cnt;

  always_comb begin
    match    = '0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
      hit_line = hit_line | ({256{match[w]}} & line_q[idx][w]);
    end
  end

  assign hit      = lookup && (|match);
  assign hit_word = hit_line[{offs, 5'd0} +: 32];

  always_comb begin
    if (hit)                       l1_data_o = hit_word;
    else if (state == S_MMIO_RET)  l1_data_o = mmio_word;
    else                           l1_data_o = '0;
  end

  always_comb begin
    case (state)
      S_IDLE:     stall = l1_read && !hit;
      S_MMIO_RET: stall = 1'b0;
      default:    stall = 1'b1;
    endcase
  end

  // Lowest invalid way wins; only a full set falls back to the round-robin pointer.
  always_comb begin
    victim = victim_q[fill_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[fill_idx][w]) victim = VW'(w);
    end
  end

  assign victim_next = (WAYS > 1) ? victim_q[fill_idx] + 1'b1 : '0;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      valid_q         <= '0;
      victim_q        <= '0;
      inval_pend      <= 1'b0;
      mmio_word       <= '0;
      inv_cnt         <= '0;
      l1_mmu_req_read <= 1'b0;
      l1_mmu_req_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (l1_inval) begin
            state   <= S_INVAL;
            inv_cnt <= '1;
          end else if (l1_read && is_mmio) begin
            state           <= S_MMIO;
            l1_mmu_req_read <= 1'b1;
            l1_mmu_req_addr <= l1_addr;
          end else if (l1_read && !hit) begin
            state           <= S_REFILL;
            l1_mmu_req_read <= 1'b1;
            l1_mmu_req_addr <= {l1_addr[31:5], 5'b0};
          end
        end
        S_REFILL: begin
          if (l1_inval) inval_pend <= 1'b1;
          if (mmu_l1_done) begin
            l1_mmu_req_read <= 1'b0;
            state           <= S_FILL;
          end
        end
        S_FILL: begin
          valid_q[fill_idx][victim] <= 1'b1;
          victim_q[fill_idx]        <= victim_next;
          if (inval_pend || l1_inval) begin
            state      <= S_INVAL;
            inv_cnt    <= '1;
            inval_pend <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_MMIO: begin
          if (l1_inval) inval_pend <= 1'b1;
          if (mmu_l1_done) begin
            mmio_word       <= mmu_l1_read_data[31:0];
            l1_mmu_req_read <= 1'b0;
            state           <= S_MMIO_RET;
          end
        end
        S_MMIO_RET: begin
          if (inval_pend || l1_inval) begin
            state      <= S_INVAL;
            inv_cnt    <= '1;
            inval_pend <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_INVAL: begin
          valid_q[inv_idx] <= '0;
          if (inv_cnt == '0) state <= S_IDLE;
          else               inv_cnt <= inv_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag and line are written as the data arrives; valid follows in FILL.
  always_ff @(posedge sys_clk) begin
    if (state == S_REFILL && mmu_l1_done) begin
      tag_q[fill_idx][victim]  <= fill_tag;
      line_q[fill_idx][victim] <= mmu_l1_read_data;
    end
  end

  ap_one_way_match: assert property (@(posedge sys_clk) disable iff (!rst_n) $onehot0(match));

endmodule

// File: doc/l1icache_nway.md
L1ICACHE_NWAY -- requirements
Module: l1icache_nway

Interface
REQ-001 Parameter WAYS, default 2, associativity; legal values 1, 2, 4.
REQ-002 Parameter SETS, default 512, sets per way; power of two, 2..1024.
REQ-003 Parameter MMIO_BASE, default 32'hFFFF_0000, uncached region base.
REQ-004 Parameter MMIO_MASK, default 32'hFFFF_0000; address is MMIO when (l1_addr & MMIO_MASK) == MMIO_BASE.
REQ-005 sys_clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 l1_read  in  1  fetch request, held with l1_addr until stall deasserts.
REQ-008 l1_addr  in  32  fetch byte address; bits [1:0] ignored.
REQ-009 l1_inval  in  1  one-cycle pulse: invalidate whole cache (fence.i).
REQ-010 l1_data_o  out  32  fetched instruction word.
REQ-011 hit  out  1  cached lookup hit this cycle.
REQ-012 stall  out  1  request not complete; pipeline holds.
REQ-013 l1_mmu_req_read  out  1  refill/MMIO read request to MMU.
REQ-014 l1_mmu_req_addr  out  32  line address {l1_addr[31:5],5'b0} if cached; l1_addr exactly if MMIO.
REQ-015 mmu_l1_done  in  1  one-cycle pulse: mmu_l1_read_data valid.
REQ-016 mmu_l1_read_data  in  256  refill line; MMIO word in [31:0].

Function
REQ-017 Address split: offset [4:2] word select, index [4+log2(SETS):5], tag = remaining upper bits (TAGW = 27 - log2(SETS)).
REQ-018 Per way per set: valid bit, TAGW-bit tag, 256-bit line; per set: victim pointer, log2(WAYS) bits (absent when WAYS=1).
REQ-019 hit = l1_read && !mmio && FSM in IDLE && any way valid with matching tag; combinational, same cycle.
REQ-020 On hit: l1_data_o = word [offset] of hitting way, stall = 0, same cycle; no state change.
REQ-021 At most one way may match; multi-match is a verification assertion failure.
REQ-022 FSM states: IDLE, REFILL, FILL, MMIO, MMIO_RET, INVAL.
REQ-023 IDLE -> REFILL when l1_read && !mmio && !hit; IDLE -> MMIO when l1_read && mmio; IDLE -> INVAL when l1_inval (priority over requests).
REQ-024 REFILL: l1_mmu_req_read = 1, address per REQ-014, held until mmu_l1_done; then -> FILL.
REQ-025 FILL (1 cycle): capture line into way = set victim pointer, valid = 1, tag written; victim pointer increments modulo WAYS; -> IDLE, where access now hits.
REQ-026 Victim choice: first invalid way (lowest index) if any, else round-robin pointer.
REQ-027 MMIO: l1_mmu_req_read = 1 until mmu_l1_done; word [31:0] latched; -> MMIO_RET.
REQ-028 MMIO_RET (1 cycle): l1_data_o = latched word, stall = 0, hit = 0; -> IDLE; MMIO data never enters cache.
REQ-029 stall = l1_read && !(hit || state == MMIO_RET), and stall = 1 whenever state is REFILL, FILL, MMIO or INVAL.
REQ-030 INVAL: clear valid bits one set per cycle, index 0..SETS-1, all ways in parallel; SETS cycles; stall = 1 if l1_read; -> IDLE.
REQ-031 l1_inval during REFILL/MMIO is recorded; INVAL entered after FILL/MMIO_RET completes; filled line is invalidated.
REQ-032 mmu_l1_done outside REFILL/MMIO is ignored.
REQ-033 l1_mmu_req_read is 0 in IDLE, FILL, MMIO_RET, INVAL.
REQ-034 l1_data_o in cycles without hit or MMIO_RET is don't-care but deterministic (no X after reset).

Reset
REQ-035 rst_n low asynchronously forces: state IDLE, all valid bits 0, victim pointers 0, pending-inval 0, MMIO latch 0, l1_mmu_req_read 0, l1_data_o 0 while no access is active.
REQ-036 Reset mid-REFILL/MMIO abandons the transaction; a late mmu_l1_done after reset is ignored per REQ-032.
REQ-037 Line data arrays need no reset.

Verification
REQ-038 Cold miss: read 0x0000_1004, MMU returns line with word1 = 0xDEAD_BEEF after 5 cycles -> req addr 0x0000_1000, stall until FILL, next cycle hit = 1, l1_data_o = 0xDEAD_BEEF.
REQ-039 Associativity (WAYS=2, SETS=512): fill 0x0000_1000, 0x0000_5000, 0x0000_9000 (same index) -> third evicts way 0; 0x0000_5000 still hits, 0x0000_1000 misses.
REQ-040 MMIO: read 0xFFFF_0010, MMU returns data[31:0] = 0x1234_5678 -> req addr 0xFFFF_0010, one MMIO_RET cycle with data 0x1234_5678, repeat read misses again (no caching).
REQ-041 Invalidate: after filling two lines, pulse l1_inval -> stall for exactly SETS cycles, then both addresses miss.
REQ-042 l1_inval pulsed during REFILL -> fill completes, then INVAL sweep runs, refetched line misses.
REQ-043 Assert rst_n low during REFILL with WAYS=4 -> req_read drops immediately, all lookups miss after reset, stray mmu_l1_done produces no fill.
